// File: rtl/itlb_refill_ctrl.sv
// ITLB miss handler: allocates a victim slot, walks the page table, then writes the entry or reports a fault.
// Optional perf counters are enabled with `define ITLB_REFILL_PERF_CNT_EN.
module itlb_refill_ctrl #(
    parameter int ENTRY_NUM = 32,
    parameter int VPN_W     = 27,
    parameter int PPN_W     = 44,
    parameter int ASID_W    = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 miss_vld_i,
    input  logic [VPN_W-1:0]     miss_vpn_i,
    input  logic [ASID_W-1:0]    miss_asid_i,
    output logic                 miss_rdy_o,
    input  logic                 flush_i,
    output logic                 refill_rq_o,
    input  logic [ENTRY_NUM-1:0] refill_onehot_i,
    output logic                 refill_vld_o,
    output logic [ENTRY_NUM-1:0] refill_we_o,
    output logic [VPN_W-1:0]     refill_vpn_o,
    output logic [ASID_W-1:0]    refill_asid_o,
    output logic [PPN_W-1:0]     refill_ppn_o,
    output logic [7:0]           refill_perm_o,
    output logic [1:0]           refill_lvl_o,
    output logic                 ptw_req_vld_o,
    input  logic                 ptw_req_rdy_i,
    output logic [VPN_W-1:0]     ptw_req_vpn_o,
    input  logic                 ptw_resp_vld_i,
    input  logic [PPN_W-1:0]     ptw_resp_ppn_i,
    input  logic [7:0]           ptw_resp_perm_i,
    input  logic [1:0]           ptw_resp_lvl_i,
    input  logic                 ptw_resp_fault_i,
    output logic                 fault_vld_o,
    output logic [VPN_W-1:0]     fault_vpn_o,
    output logic                 busy_o,
    output logic [31:0]          refill_cnt_o,
    output logic [31:0]          fault_cnt_o
);

    typedef enum logic [2:0] {
        IDLE, ALLOC, PTW_REQ, PTW_WAIT, WRITE, DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [VPN_W-1:0]    vpn_q;
    logic [ASID_W-1:0]   asid_q;
    logic [PPN_W-1:0]    ppn_q;
    logic [7:0]          perm_q;
    logic [1:0]          lvl_q;
    logic                fault_q, fault_d;
    logic                accept, resp_take, resp_bad;

    assign accept    = (state_q == IDLE) && miss_vld_i && !flush_i;
    assign resp_take = (state_q == PTW_WAIT) && ptw_resp_vld_i && !flush_i;
    // Level 3 does not exist in Sv39, so it is treated like an invalid PTE.
    assign resp_bad  = ptw_resp_fault_i || !ptw_resp_perm_i[0] || (ptw_resp_lvl_i == 2'd3);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        fault_d = 1'b0;
        case (state_q)
            IDLE:     if (accept) state_d = ALLOC;
            ALLOC:    state_d = flush_i ? IDLE : PTW_REQ;
            PTW_REQ: begin
                if (ptw_req_rdy_i)  state_d = flush_i ? DRAIN : PTW_WAIT;
                else if (flush_i)   state_d = IDLE;
            end
            PTW_WAIT: begin
                if (ptw_resp_vld_i) begin
                    if (flush_i)       state_d = IDLE;
                    else if (resp_bad) begin
                        state_d = IDLE;
                        fault_d = 1'b1;
                    end else           state_d = WRITE;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            WRITE:    state_d = IDLE;
            DRAIN:    if (ptw_resp_vld_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
            vpn_q   <= '0;
            asid_q  <= '0;
            ppn_q   <= '0;
            perm_q  <= '0;
            lvl_q   <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            if (accept) begin
                vpn_q  <= miss_vpn_i;
                asid_q <= miss_asid_i;
            end
            if (resp_take) begin
                ppn_q  <= ptw_resp_ppn_i;
                perm_q <= ptw_resp_perm_i;
                lvl_q  <= ptw_resp_lvl_i;
            end
        end
    end

    assign miss_rdy_o    = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign refill_rq_o   = (state_q == ALLOC);
    assign ptw_req_vld_o = (state_q == PTW_REQ);
    assign ptw_req_vpn_o = vpn_q;
    assign refill_vld_o  = (state_q == WRITE);
    assign refill_we_o   = (state_q == WRITE) ? refill_onehot_i : '0;
    assign refill_vpn_o  = vpn_q;
    assign refill_asid_o = asid_q;
    assign refill_ppn_o  = ppn_q;
    assign refill_perm_o = perm_q;
    assign refill_lvl_o  = lvl_q;
    assign fault_vld_o   = fault_q;
    assign fault_vpn_o   = vpn_q;

`ifdef ITLB_REFILL_PERF_CNT_EN
    logic [31:0] refill_cnt_q, fault_cnt_q;

    // Saturating counters; a flush never clears them.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            refill_cnt_q <= '0;
            fault_cnt_q  <= '0;
        end else begin
            if ((state_q == WRITE) && (refill_cnt_q != '1)) refill_cnt_q <= refill_cnt_q + 32'd1;
            if (fault_q && (fault_cnt_q != '1))             fault_cnt_q  <= fault_cnt_q + 32'd1;
        end
    end

    assign refill_cnt_o = refill_cnt_q;
    assign fault_cnt_o  = fault_cnt_q;
`else
    assign refill_cnt_o = '0;
    assign fault_cnt_o  = '0;
`endif

    // A non-one-hot victim is still written as-is, but it signals a replacement-unit bug.
    a_victim_onehot: assert property (@(posedge clk_i) disable iff (!rstn_i)
        (state_q == WRITE) |-> $onehot(refill_onehot_i));

endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// Self-checking bench for itlb_refill_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_itlb_refill_ctrl;

    localparam int ENTRY_NUM = 32;
    localparam int VPN_W     = 27;
    localparam int PPN_W     = 44;
    localparam int ASID_W    = 16;

    logic                 clk_i = 1'b0;
    logic                 rstn_i;
    logic                 miss_vld_i;
    logic [VPN_W-1:0]     miss_vpn_i;
    logic [ASID_W-1:0]    miss_asid_i;
    logic                 miss_rdy_o;
    logic                 flush_i;
    logic                 refill_rq_o;
    logic [ENTRY_NUM-1:0] refill_onehot_i;
    logic                 refill_vld_o;
    logic [ENTRY_NUM-1:0] refill_we_o;
    logic [VPN_W-1:0]     refill_vpn_o;
    logic [ASID_W-1:0]    refill_asid_o;
    logic [PPN_W-1:0]     refill_ppn_o;
    logic [7:0]           refill_perm_o;
    logic [1:0]           refill_lvl_o;
    logic                 ptw_req_vld_o;
    logic                 ptw_req_rdy_i;
    logic [VPN_W-1:0]     ptw_req_vpn_o;
    logic                 ptw_resp_vld_i;
    logic [PPN_W-1:0]     ptw_resp_ppn_i;
    logic [7:0]           ptw_resp_perm_i;
    logic [1:0]           ptw_resp_lvl_i;
    logic                 ptw_resp_fault_i;
    logic                 fault_vld_o;
    logic [VPN_W-1:0]     fault_vpn_o;
    logic                 busy_o;
    logic [31:0]          refill_cnt_o;
    logic [31:0]          fault_cnt_o;

    itlb_refill_ctrl #(
        .ENTRY_NUM(ENTRY_NUM), .VPN_W(VPN_W), .PPN_W(PPN_W), .ASID_W(ASID_W)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .miss_vld_i(miss_vld_i), .miss_vpn_i(miss_vpn_i), .miss_asid_i(miss_asid_i),
        .miss_rdy_o(miss_rdy_o), .flush_i(flush_i),
        .refill_rq_o(refill_rq_o), .refill_onehot_i(refill_onehot_i),
        .refill_vld_o(refill_vld_o), .refill_we_o(refill_we_o),
        .refill_vpn_o(refill_vpn_o), .refill_asid_o(refill_asid_o),
        .refill_ppn_o(refill_ppn_o), .refill_perm_o(refill_perm_o), .refill_lvl_o(refill_lvl_o),
        .ptw_req_vld_o(ptw_req_vld_o), .ptw_req_rdy_i(ptw_req_rdy_i), .ptw_req_vpn_o(ptw_req_vpn_o),
        .ptw_resp_vld_i(ptw_resp_vld_i), .ptw_resp_ppn_i(ptw_resp_ppn_i),
        .ptw_resp_perm_i(ptw_resp_perm_i), .ptw_resp_lvl_i(ptw_resp_lvl_i),
        .ptw_resp_fault_i(ptw_resp_fault_i),
        .fault_vld_o(fault_vld_o), .fault_vpn_o(fault_vpn_o), .busy_o(busy_o),
        .refill_cnt_o(refill_cnt_o), .fault_cnt_o(fault_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model: what the current miss is waiting for, plus the captured fields.
    logic              m_rq, m_walk, m_wait, m_drain, m_write, m_fault;
    logic [VPN_W-1:0]  m_vpn;
    logic [ASID_W-1:0] m_asid;
    logic [PPN_W-1:0]  m_ppn;
    logic [7:0]        m_perm;
    logic [1:0]        m_lvl;
    logic [31:0]       m_rcnt, m_fcnt;

    // Observations captured by run_txn for literal checks.
    int                req_cycles;
    logic              last_fault, last_vld;
    logic [VPN_W-1:0]  last_fvpn;
    logic [ENTRY_NUM-1:0] last_we;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        {m_rq, m_walk, m_wait, m_drain, m_write, m_fault} = '0;
        m_vpn = '0; m_asid = '0; m_ppn = '0; m_perm = '0; m_lvl = '0;
        m_rcnt = '0; m_fcnt = '0;
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // One clock: compare outputs against the model, then advance the model on the edge.
    task automatic cycle();
        logic busy_e;
        logic n_rq, n_walk, n_wait, n_drain, n_write, n_fault;
        #1;
        busy_e = m_rq | m_walk | m_wait | m_drain | m_write;
        check("busy", 64'(busy_o), 64'(busy_e));
        check("miss_rdy", 64'(miss_rdy_o), 64'(!busy_e));
        check("refill_rq", 64'(refill_rq_o), 64'(m_rq));
        check("ptw_req_vld", 64'(ptw_req_vld_o), 64'(m_walk));
        if (m_walk) check("ptw_req_vpn", 64'(ptw_req_vpn_o), 64'(m_vpn));
        check("refill_vld", 64'(refill_vld_o), 64'(m_write));
        check("refill_we", 64'(refill_we_o), m_write ? 64'(refill_onehot_i) : 64'd0);
        if (m_write) begin
            check("refill_vpn", 64'(refill_vpn_o), 64'(m_vpn));
            check("refill_asid", 64'(refill_asid_o), 64'(m_asid));
            check("refill_ppn", 64'(refill_ppn_o), 64'(m_ppn));
            check("refill_perm", 64'(refill_perm_o), 64'(m_perm));
            check("refill_lvl", 64'(refill_lvl_o), 64'(m_lvl));
        end
        check("fault_vld", 64'(fault_vld_o), 64'(m_fault));
        if (m_fault) check("fault_vpn", 64'(fault_vpn_o), 64'(m_vpn));
`ifdef ITLB_REFILL_PERF_CNT_EN
        check("refill_cnt", 64'(refill_cnt_o), 64'(m_rcnt));
        check("fault_cnt", 64'(fault_cnt_o), 64'(m_fcnt));
`else
        check("refill_cnt", 64'(refill_cnt_o), 64'd0);
        check("fault_cnt", 64'(fault_cnt_o), 64'd0);
`endif
        @(posedge clk_i);
        {n_rq, n_walk, n_wait, n_drain, n_write, n_fault} = '0;
        if (!rstn_i) begin
            model_reset();
        end else begin
            if (m_write) m_rcnt = sat_inc(m_rcnt);
            if (m_fault) m_fcnt = sat_inc(m_fcnt);
            if (!busy_e && miss_vld_i && !flush_i) begin
                m_vpn = miss_vpn_i; m_asid = miss_asid_i; n_rq = 1'b1;
            end
            if (m_rq && !flush_i) n_walk = 1'b1;
            if (m_walk) begin
                if (ptw_req_rdy_i) begin
                    if (flush_i) n_drain = 1'b1; else n_wait = 1'b1;
                end else if (!flush_i) n_walk = 1'b1;
            end
            if (m_wait) begin
                if (ptw_resp_vld_i) begin
                    if (!flush_i) begin
                        m_ppn = ptw_resp_ppn_i; m_perm = ptw_resp_perm_i; m_lvl = ptw_resp_lvl_i;
                        if (ptw_resp_fault_i || !ptw_resp_perm_i[0] || ptw_resp_lvl_i == 2'd3) n_fault = 1'b1;
                        else n_write = 1'b1;
                    end
                end else if (flush_i) n_drain = 1'b1;
                else n_wait = 1'b1;
            end
            if (m_drain && !ptw_resp_vld_i) n_drain = 1'b1;
            {m_rq, m_walk, m_wait, m_drain, m_write, m_fault} = {n_rq, n_walk, n_wait, n_drain, n_write, n_fault};
        end
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        miss_vld_i = 1'b0; flush_i = 1'b0; ptw_req_rdy_i = 1'b0; ptw_resp_vld_i = 1'b0;
        ptw_resp_fault_i = 1'b0;
    endtask

    // Full miss: stall = cycles with rdy low before the handshake, delay = idle cycles before the response.
    task automatic run_txn(input logic [VPN_W-1:0] vpn, input logic [ASID_W-1:0] asid,
                           input logic [PPN_W-1:0] ppn, input logic [7:0] perm,
                           input logic [1:0] lvl, input logic flt, input int stall, input int delay);
        req_cycles = 0;
        miss_vld_i = 1'b1; miss_vpn_i = vpn; miss_asid_i = asid;
        cycle();
        miss_vld_i = 1'b0;
        cycle();
        for (int i = 0; i <= stall; i++) begin
            ptw_req_rdy_i = (i == stall);
            #1;
            if (ptw_req_vld_o && ptw_req_vpn_o == vpn) req_cycles++;
            cycle();
        end
        ptw_req_rdy_i = 1'b0;
        for (int i = 0; i < delay; i++) cycle();
        ptw_resp_vld_i = 1'b1; ptw_resp_ppn_i = ppn; ptw_resp_perm_i = perm;
        ptw_resp_lvl_i = lvl; ptw_resp_fault_i = flt;
        cycle();
        ptw_resp_vld_i = 1'b0; ptw_resp_fault_i = 1'b0;
        #1;
        last_fault = fault_vld_o; last_fvpn = fault_vpn_o; last_vld = refill_vld_o; last_we = refill_we_o;
        cycle();
    endtask

    initial begin
        rstn_i = 1'b0;
        idle_inputs();
        miss_vpn_i = '0; miss_asid_i = '0; refill_onehot_i = 32'h0000_0004;
        ptw_resp_ppn_i = '0; ptw_resp_perm_i = '0; ptw_resp_lvl_i = '0;
        model_reset();
        @(negedge clk_i); @(negedge clk_i);

        // Reset state
        check("rst_miss_rdy", 64'(miss_rdy_o), 64'd1);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_refill_we", 64'(refill_we_o), 64'd0);
        check("rst_ptw_req_vld", 64'(ptw_req_vld_o), 64'd0);
        check("rst_refill_ppn", 64'(refill_ppn_o), 64'd0);
        rstn_i = 1'b1;
        cycle();

        // Basic refill with literal latency: accept c0, rq c1, req c2, resp c5, write c6, ready c7
        miss_vld_i = 1'b1; miss_vpn_i = 27'h1234; miss_asid_i = 16'd5; ptw_req_rdy_i = 1'b1;
        #1 check("s1_c0_miss_rdy", 64'(miss_rdy_o), 64'd1);
        cycle();
        miss_vld_i = 1'b0;
        #1 check("s1_c1_refill_rq", 64'(refill_rq_o), 64'd1);
        cycle();
        #1 check("s1_c2_ptw_req_vld", 64'(ptw_req_vld_o), 64'd1);
        cycle();
        ptw_req_rdy_i = 1'b0;
        cycle(); cycle();
        ptw_resp_vld_i = 1'b1; ptw_resp_ppn_i = 44'hABCDE; ptw_resp_perm_i = 8'hCF; ptw_resp_lvl_i = 2'd0;
        cycle();
        ptw_resp_vld_i = 1'b0;
        #1;
        check("s1_c6_refill_vld", 64'(refill_vld_o), 64'd1);
        check("s1_c6_refill_we", 64'(refill_we_o), 64'h4);
        check("s1_c6_refill_ppn", 64'(refill_ppn_o), 64'hABCDE);
        cycle();
        #1 check("s1_c7_miss_rdy", 64'(miss_rdy_o), 64'd1);
        cycle();

        // Walker stalls 5 cycles: request held 6 cycles, then a write
        refill_onehot_i = 32'h0001_0000;
        run_txn(27'h2A5A5, 16'h00F1, 44'h123_4567_89AB, 8'hC3, 2'd1, 1'b0, 5, 2);
        check("stall_req_cycles", 64'(req_cycles), 64'd6);
        check("stall_write", 64'(last_vld), 64'd1);
        check("stall_we", 64'(last_we), 64'h0001_0000);

        refill_onehot_i = 32'h8000_0000;
        run_txn(27'h0777, 16'h0002, 44'h0F0F, 8'h0B, 2'd2, 1'b0, 0, 0);
        check("plain_we", 64'(last_we), 64'h8000_0000);

        // Faults: walker fault, V=0, level 3
        run_txn(27'h55, 16'h1, 44'h1, 8'hCF, 2'd0, 1'b1, 0, 1);
        check("flt_walk_vld", 64'(last_fault), 64'd1);
        check("flt_walk_vpn", 64'(last_fvpn), 64'h55);
        check("flt_walk_we", 64'(last_we), 64'd0);
        run_txn(27'h55, 16'h1, 44'h1, 8'h0E, 2'd0, 1'b0, 1, 0);
        check("flt_v0_vld", 64'(last_fault), 64'd1);
        check("flt_v0_vpn", 64'(last_fvpn), 64'h55);
        check("flt_v0_we", 64'(last_we), 64'd0);
        cycle();
`ifdef ITLB_REFILL_PERF_CNT_EN
        check("cnt_refill_3", 64'(refill_cnt_o), 64'd3);
        check("cnt_fault_2", 64'(fault_cnt_o), 64'd2);
`else
        check("cnt_refill_off", 64'(refill_cnt_o), 64'd0);
        check("cnt_fault_off", 64'(fault_cnt_o), 64'd0);
`endif
        run_txn(27'h55, 16'h1, 44'h1, 8'hCF, 2'd3, 1'b0, 0, 2);
        check("flt_lvl3_vld", 64'(last_fault), 64'd1);
        check("flt_lvl3_vpn", 64'(last_fvpn), 64'h55);
        check("flt_lvl3_we", 64'(last_vld), 64'd0);

        // Flush in PTW_WAIT, response 4 cycles later; misses during DRAIN are refused
        miss_vld_i = 1'b1; miss_vpn_i = 27'h0ABC; miss_asid_i = 16'h7;
        cycle();
        miss_vld_i = 1'b0; cycle();
        ptw_req_rdy_i = 1'b1; cycle();
        ptw_req_rdy_i = 1'b0; flush_i = 1'b1; cycle();
        flush_i = 1'b0; miss_vld_i = 1'b1; miss_vpn_i = 27'h0DEF;
        for (int i = 0; i < 3; i++) begin
            #1 check("drain_miss_rdy", 64'(miss_rdy_o), 64'd0);
            cycle();
        end
        ptw_resp_vld_i = 1'b1; ptw_resp_perm_i = 8'hCF; ptw_resp_lvl_i = 2'd0;
        #1 check("drain_resp_miss_rdy", 64'(miss_rdy_o), 64'd0);
        check("drain_no_write", 64'(refill_vld_o), 64'd0);
        cycle();
        ptw_resp_vld_i = 1'b0; miss_vld_i = 1'b0;
        #1 check("drain_done_miss_rdy", 64'(miss_rdy_o), 64'd1);
        check("drain_miss_dropped", 64'(refill_rq_o), 64'd0);
        cycle();

        // Flush coincident with a miss in IDLE
        miss_vld_i = 1'b1; flush_i = 1'b1; cycle();
        idle_inputs();
        #1 check("idle_flush_rq", 64'(refill_rq_o), 64'd0);
        check("idle_flush_busy", 64'(busy_o), 64'd0);
        cycle();

        // Async reset while waiting for the walker
        miss_vld_i = 1'b1; miss_vpn_i = 27'h1111; cycle();
        miss_vld_i = 1'b0; cycle();
        ptw_req_rdy_i = 1'b1; cycle();
        ptw_req_rdy_i = 1'b0;
        rstn_i = 1'b0; model_reset();
        #1 check("areset_busy", 64'(busy_o), 64'd0);
        cycle();
        rstn_i = 1'b1; cycle();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 699) == 0) begin
                rstn_i = 1'b0; model_reset();
            end else begin
                rstn_i = 1'b1;
            end
            miss_vld_i       = 1'($urandom_range(0, 1));
            miss_vpn_i       = VPN_W'($urandom);
            miss_asid_i      = ASID_W'($urandom);
            flush_i          = ($urandom_range(0, 19) == 0);
            ptw_req_rdy_i    = 1'($urandom_range(0, 1));
            ptw_resp_vld_i   = ($urandom_range(0, 3) == 0);
            ptw_resp_ppn_i   = PPN_W'({$urandom, $urandom});
            ptw_resp_perm_i  = 8'($urandom);
            ptw_resp_perm_i[0] = ($urandom_range(0, 4) != 0);
            ptw_resp_lvl_i   = 2'($urandom_range(0, 3));
            ptw_resp_fault_i = ($urandom_range(0, 5) == 0);
            if (m_rq) refill_onehot_i = 32'd1 << $urandom_range(0, 31);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
